free_tag_pool: RTL
==================

Name: free_tag_pool

Overview:
- Physical-tag free list for the Rename stage.
- Hands out up to two unused physical tags per cycle to Rename for new destination mappings.
- Takes back up to two tags per cycle from the reorder buffer's retire outputs (freed_tag_1/2; value 0 means "nothing freed").
- Circular FIFO of tags; p0 is never stored or allocated.

Parameters:
NUM_TAGS, 64, number of physical tags p0..NUM_TAGS-1; FIFO depth equals NUM_TAGS
TAG_W, 6, tag width; must equal log2(NUM_TAGS)
INIT_FREE_BASE, 32, first tag loaded free at reset; tags below it are architecturally mapped

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
alloc_en_1  input  1  Rename consumes alloc_tag_1 this cycle
alloc_en_2  input  1  Rename consumes alloc_tag_2 this cycle; honoured only together with alloc_en_1
freed_tag_1  input  TAG_W  tag returned by ROB; 0 = none
freed_tag_2  input  TAG_W  second tag returned by ROB; 0 = none
alloc_tag_1  output  TAG_W  tag at FIFO head; 0 when free_count==0
alloc_tag_2  output  TAG_W  tag at head+1; 0 when free_count<2
can_alloc_1  output  1  free_count>=1
can_alloc_2  output  1  free_count>=2
free_count  output  TAG_W+1  tags currently in pool

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Storage: array of NUM_TAGS entries of TAG_W bits, head and tail pointers (TAG_W bits, wrap modulo NUM_TAGS), count register (TAG_W+1 bits).
- Reset, sampled at posedge with reset=1:
  - Entries 0..(NUM_TAGS-INIT_FREE_BASE-1) hold INIT_FREE_BASE..NUM_TAGS-1 in ascending order.
  - head=0; tail=NUM_TAGS-INIT_FREE_BASE mod NUM_TAGS; count=NUM_TAGS-INIT_FREE_BASE (32 by default).
  - Alloc/free inputs in that cycle are ignored. Reset mid-operation discards all outstanding state.
- Outputs are combinational from registered state: alloc_tag_1=mem[head], alloc_tag_2=mem[head+1 wrapped], with 0 substitution as above. No same-cycle bypass of freed tags.
- Pops per cycle:
  - pop1 = alloc_en_1 & can_alloc_1.
  - pop2 = alloc_en_1 & alloc_en_2 & can_alloc_2.
  - alloc_en_2 alone pops nothing. Requests beyond availability are dropped silently; Rename must check can_alloc_*.
  - head advances by pop1+pop2.
- Pushes per cycle:
  - Only nonzero freed tags are written; they are compacted toward tail.
  - Both nonzero: freed_tag_1 at tail, freed_tag_2 at tail+1.
  - Only one nonzero: written at tail.
  - tail advances by the number of nonzero freed tags.
- Count: count_next = count + pushes - pops, computed in TAG_W+1 bits.
- Simultaneous push and pop: both use pre-update pointers.
  - When count==0, pushed tags become visible next cycle; no pop occurs that cycle.
- Full: at most NUM_TAGS-1 tags can legally be free (p0 never present). Pushes that would exceed NUM_TAGS-1 are an upstream bug.
  - Without the checker: the write still occurs and count is clamped to NUM_TAGS-1.
- Latency: tag freed in cycle N is allocatable no earlier than cycle N+1, and only once it reaches head.

Optional Feature:
Macro: FREE_POOL_CHECK_EN
- Defined:
  - Maintain a NUM_TAGS-bit in_pool bitmap, set for tags INIT_FREE_BASE..NUM_TAGS-1 at reset.
  - Each popped tag clears its bit.
  - $fatal on any of:
    - pushing a tag whose bit is already set (double free);
    - pushing when count would exceed NUM_TAGS-1;
    - popping a tag whose bit is clear;
    - count > NUM_TAGS-1 at any posedge.
- Undefined: no bitmap, no $fatal; clamp behaviour above applies.

Test Plan:
1. Reset, then idle -> free_count=32, alloc_tag_1=32, alloc_tag_2=33, can_alloc_2=1.
2. alloc_en_1=1 and alloc_en_2=1 for 16 cycles -> tags 32..63 handed out in order; free_count=0; alloc_tag_1=alloc_tag_2=0; can_alloc_1=0.
3. From empty: freed_tag_1=0, freed_tag_2=40 in one cycle -> next cycle free_count=1, alloc_tag_1=40, alloc_tag_2=0, can_alloc_2=0.
4. free_count=1 (head=40), alloc_en_1=1 and alloc_en_2=1 with freed_tag_1=5, freed_tag_2=7 -> pops 40 only; next cycle free_count=2, alloc_tag_1=5, alloc_tag_2=7.
5. Wrap-around: 100 cycles of paired alloc/free recycling tags -> pointers wrap past 63; allocation order equals free order; free_count stays constant.
6. With FREE_POOL_CHECK_EN: after reset free tag 33 (already free) -> $fatal. Also assert reset mid-stream -> state equals test 1 on the next cycle.

Source files
------------

// File: rtl/free_tag_pool.sv
// Physical-tag free list for Rename: circular FIFO that hands out two tags per cycle and takes back two from retire.
// Define FREE_POOL_CHECK_EN to enable the in-pool bitmap and $fatal checks on double free, overflow and bad pops.
module free_tag_pool #(
  parameter int NUM_TAGS       = 64,
  parameter int TAG_W          = 6,
  parameter int INIT_FREE_BASE = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en_1,
  input  logic             alloc_en_2,
  input  logic [TAG_W-1:0] freed_tag_1,
  input  logic [TAG_W-1:0] freed_tag_2,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  output logic             can_alloc_1,
  output logic             can_alloc_2,
  output logic [TAG_W:0]   free_count
);
  localparam logic [TAG_W:0]   CAP        = (TAG_W+1)'(NUM_TAGS - 1);
  localparam logic [TAG_W:0]   INIT_CNT   = (TAG_W+1)'(NUM_TAGS - INIT_FREE_BASE);
  localparam logic [TAG_W-1:0] INIT_TAIL  = TAG_W'(NUM_TAGS - INIT_FREE_BASE);

  logic [TAG_W-1:0] r_mem [NUM_TAGS];
  logic [TAG_W-1:0] r_head, r_tail;
  logic [TAG_W:0]   r_count;

  logic [TAG_W-1:0] w_head1, w_tail1, w_wr2_addr;
  logic             w_pop1, w_pop2, w_v1, w_v2;
  logic [TAG_W:0]   w_npop, w_npush, w_sum, w_count_nxt;

  assign w_head1     = r_head + TAG_W'(1);
  assign w_tail1     = r_tail + TAG_W'(1);
  assign can_alloc_1 = (r_count != '0);
  assign can_alloc_2 = (r_count >= (TAG_W+1)'(2));
  assign alloc_tag_1 = can_alloc_1 ? r_mem[r_head]  : '0;
  assign alloc_tag_2 = can_alloc_2 ? r_mem[w_head1] : '0;
  assign free_count  = r_count;

  assign w_pop1  = alloc_en_1 & can_alloc_1;
  assign w_pop2  = alloc_en_1 & alloc_en_2 & can_alloc_2;
  assign w_v1    = (freed_tag_1 != '0);
  assign w_v2    = (freed_tag_2 != '0);
  assign w_npop  = (TAG_W+1)'(w_pop1) + (TAG_W+1)'(w_pop2);
  assign w_npush = (TAG_W+1)'(w_v1) + (TAG_W+1)'(w_v2);
  // Pops never exceed count, so no underflow; overflow past capacity is an upstream bug and is clamped.
  assign w_sum       = r_count + w_npush - w_npop;
  assign w_count_nxt = (w_sum > CAP) ? CAP : w_sum;
  assign w_wr2_addr  = w_v1 ? w_tail1 : r_tail;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++)
        r_mem[i] <= (i < NUM_TAGS - INIT_FREE_BASE) ? TAG_W'(INIT_FREE_BASE + i) : '0;
      r_head  <= '0;
      r_tail  <= INIT_TAIL;
      r_count <= INIT_CNT;
    end else begin
      if (w_v1) r_mem[r_tail]     <= freed_tag_1;
      if (w_v2) r_mem[w_wr2_addr] <= freed_tag_2;
      r_head  <= r_head + w_npop[TAG_W-1:0];
      r_tail  <= r_tail + w_npush[TAG_W-1:0];
      r_count <= w_count_nxt;
    end
  end

`ifdef FREE_POOL_CHECK_EN
  logic [NUM_TAGS-1:0] r_in_pool;
  logic [NUM_TAGS-1:0] w_bm_nxt;

  always_comb begin
    w_bm_nxt = r_in_pool;
    if (w_pop1) w_bm_nxt[alloc_tag_1] = 1'b0;
    if (w_pop2) w_bm_nxt[alloc_tag_2] = 1'b0;
    if (w_v1)   w_bm_nxt[freed_tag_1] = 1'b1;
    if (w_v2)   w_bm_nxt[freed_tag_2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++)
        r_in_pool[i] <= (i >= INIT_FREE_BASE);
    end else begin
      if ((w_v1 && r_in_pool[freed_tag_1]) || (w_v2 && r_in_pool[freed_tag_2]) ||
          (w_v1 && w_v2 && freed_tag_1 == freed_tag_2))
        $fatal(1, "free_tag_pool: double free");
      if (w_sum > CAP)
        $fatal(1, "free_tag_pool: push overflow");
      if ((w_pop1 && !r_in_pool[alloc_tag_1]) || (w_pop2 && !r_in_pool[alloc_tag_2]))
        $fatal(1, "free_tag_pool: popped tag not in pool");
      if (r_count > CAP)
        $fatal(1, "free_tag_pool: count exceeds capacity");
      r_in_pool <= w_bm_nxt;
    end
  end
`endif

endmodule
